ex_wb_stage: RTL and testbench

//  Stage 2 of the three-stage RV32I pipeline, directly downstream of fetch/decode.

---
 rtl/ex_wb_stage_pkg.sv | 58 +++++
 rtl/ex_wb_stage_alu.sv | 49 ++++
 rtl/ex_wb_stage.sv | 198 +++++++++++++++++++
 tb/tb_ex_wb_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_wb_stage_pkg.sv
// Shared encodings for the EX/WB stage: func3 codes, FSM states and load/store lane helpers.
package ex_wb_stage_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;

  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;

  // size = func3[1:0]: 00 byte, 01 half, 10 word; 11 is never a legal access
  function automatic logic access_ok(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   access_ok = 1'b1;
      2'b01:   access_ok = ~lo[0];
      2'b10:   access_ok = (lo == 2'b00);
      default: access_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [31:0] raw, input logic [1:0] lane,
                                             input logic [2:0] f3);
    logic [31:0] sh;
    sh = raw >> {lane, 3'b000};
    case (f3)
      F3_LB:   load_align = {{24{sh[7]}}, sh[7:0]};
      F3_LH:   load_align = {{16{sh[15]}}, sh[15:0]};
      F3_LBU:  load_align = {24'd0, sh[7:0]};
      F3_LHU:  load_align = {16'd0, sh[15:0]};
      default: load_align = sh;
    endcase
  endfunction

endpackage

// File: rtl/ex_wb_stage_alu.sv
// Combinational RV32I ALU plus branch comparator on the bypassed source operands.
module ex_alu
  import ex_wb_stage_pkg::*;
(
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic [31:0] i_op2,
  input  logic [2:0]  i_func3,
  input  logic        i_subtype,
  output logic [31:0] o_result,
  output logic        o_br_taken
);

  logic w_eq, w_lt, w_ltu;

  assign w_eq  = (i_rs1 == i_rs2);
  assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
  assign w_ltu = (i_rs1 < i_rs2);

  always_comb begin
    o_result = '0;
    case (i_func3)
      F3_ADD:  o_result = i_subtype ? (i_rs1 - i_op2) : (i_rs1 + i_op2);
      F3_SLL:  o_result = i_rs1 << i_op2[4:0];
      F3_SLT:  o_result = {31'd0, $signed(i_rs1) < $signed(i_op2)};
      F3_SLTU: o_result = {31'd0, i_rs1 < i_op2};
      F3_XOR:  o_result = i_rs1 ^ i_op2;
      F3_SR:   o_result = i_subtype ? $unsigned($signed(i_rs1) >>> i_op2[4:0])
                                    : (i_rs1 >> i_op2[4:0]);
      F3_OR:   o_result = i_rs1 | i_op2;
      F3_AND:  o_result = i_rs1 & i_op2;
      default: o_result = '0;
    endcase
  end

  always_comb begin
    o_br_taken = 1'b0;
    case (i_func3)
      F3_BEQ:  o_br_taken = w_eq;
      F3_BNE:  o_br_taken = ~w_eq;
      F3_BLT:  o_br_taken = w_lt;
      F3_BGE:  o_br_taken = ~w_lt;
      F3_BLTU: o_br_taken = w_ltu;
      F3_BGEU: o_br_taken = ~w_ltu;
      default: o_br_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute/writeback stage: ALU, branch resolution, data-memory FSM and registered wb bundle.
module ex_wb_stage
  import ex_wb_stage_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic        ex_imm_sel,
  input  logic        ex_alu,
  input  logic        ex_lui,
  input  logic        ex_jal,
  input  logic        ex_jalr,
  input  logic        ex_branch,
  input  logic        ex_mem_write,
  input  logic        ex_mem_to_reg,
  input  logic [2:0]  ex_func3,
  input  logic        ex_subtype,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        stall,
  output logic [31:0] wb_result,
  output logic [31:0] wb_read_data,
  output logic [4:0]  wb_dest_reg_sel,
  output logic        wb_alu_to_reg,
  output logic        wb_mem_to_reg,
  output logic        wb_stall,
  output logic        exception
);

  localparam logic [31:0] TO_LAST = (MEM_TIMEOUT == 0) ? 32'd0 : 32'(MEM_TIMEOUT - 1);

  state_e      r_state;
  logic        r_squash;
  logic [31:0] r_cnt;
  logic [31:0] r_addr, r_wdata, r_res;
  logic [3:0]  r_be;
  logic [2:0]  r_func3;
  logic [4:0]  r_rd;
  logic        r_we, r_load;

  logic [31:0] w_op2, w_alu, w_result, w_mem_addr, w_target;
  logic [31:0] w_st_wdata, w_sel_addr, w_sel_wdata, w_sel_res;
  logic [3:0]  w_st_be, w_sel_be;
  logic [2:0]  w_sel_f3;
  logic [4:0]  w_sel_rd;
  logic        w_br_taken, w_jump, w_active, w_tgt_misal, w_redirect;
  logic        w_mem, w_mem_ok, w_mem_misal, w_mem_go, w_wait, w_timeout;
  logic        w_req, w_retire, w_sel_we, w_sel_load, w_we_now;

  assign w_op2 = ex_imm_sel ? ex_imm : ex_rs2;

  ex_alu u_alu (
    .i_rs1      (ex_rs1),
    .i_rs2      (ex_rs2),
    .i_op2      (w_op2),
    .i_func3    (ex_func3),
    .i_subtype  (ex_subtype),
    .o_result   (w_alu),
    .o_br_taken (w_br_taken)
  );

  assign w_result   = ex_lui ? ex_imm : ((ex_jal | ex_jalr) ? (ex_pc + 32'd4) : w_alu);
  assign w_mem_addr = ex_rs1 + ex_imm;
  assign w_target   = ex_jalr ? (w_mem_addr & ~32'd1) : (ex_pc + ex_imm);
  assign w_jump     = ex_jal | ex_jalr | (ex_branch & w_br_taken);

  assign w_active    = ex_valid && !r_squash && (r_state == ST_RUN);
  assign w_tgt_misal = w_active && w_jump && w_target[1];
  assign w_redirect  = w_active && w_jump && !w_target[1];

  assign w_mem       = ex_mem_write | ex_mem_to_reg;
  assign w_mem_ok    = access_ok(ex_func3[1:0], w_mem_addr[1:0]);
  assign w_mem_misal = w_active && w_mem && !w_mem_ok;
  assign w_mem_go    = w_active && w_mem && w_mem_ok;

  assign w_wait    = (r_state == ST_WAIT);
  assign w_timeout = (MEM_TIMEOUT != 0) && w_wait && !dmem_ready && (r_cnt == TO_LAST);
  assign w_req     = w_mem_go || w_wait;
  assign w_retire  = (w_active && !(w_mem_go && !dmem_ready)) || (w_wait && dmem_ready);

  always_comb begin
    w_st_wdata = ex_rs2;
    w_st_be    = 4'b1111;
    case (ex_func3[1:0])
      2'b00: begin
        w_st_wdata = {4{ex_rs2[7:0]}};
        w_st_be    = 4'b0001 << w_mem_addr[1:0];
      end
      2'b01: begin
        w_st_wdata = {2{ex_rs2[15:0]}};
        w_st_be    = w_mem_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign w_we_now = (ex_rd != 5'd0) && !ex_mem_write && !ex_branch && !w_mem_misal && !w_tgt_misal;

  // While waiting, the access and its wb fields come from the copy taken at issue
  assign w_sel_addr  = w_wait ? r_addr  : w_mem_addr;
  assign w_sel_wdata = w_wait ? r_wdata : w_st_wdata;
  assign w_sel_be    = w_wait ? r_be    : w_st_be;
  assign w_sel_f3    = w_wait ? r_func3 : ex_func3;
  assign w_sel_rd    = w_wait ? r_rd    : ex_rd;
  assign w_sel_res   = w_wait ? r_res   : w_result;
  assign w_sel_load  = w_wait ? r_load  : (ex_mem_to_reg && !w_mem_misal);
  assign w_sel_we    = w_wait ? (r_load && (r_rd != 5'd0)) : w_we_now;

  assign dmem_req    = reset & w_req;
  assign dmem_we     = dmem_req & (w_wait ? r_we : ex_mem_write);
  assign dmem_addr   = dmem_req ? {w_sel_addr[31:2], 2'b00} : '0;
  assign dmem_wdata  = dmem_req ? w_sel_wdata : '0;
  assign dmem_be     = dmem_req ? w_sel_be : '0;

  assign redirect    = reset & w_redirect;
  assign redirect_pc = redirect ? w_target : '0;
  assign stall       = reset & ((w_mem_go && !dmem_ready) || (w_wait && !dmem_ready && !w_timeout));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_RUN;
      r_squash        <= 1'b0;
      r_cnt           <= '0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_res           <= '0;
      r_be            <= '0;
      r_func3         <= '0;
      r_rd            <= '0;
      r_we            <= 1'b0;
      r_load          <= 1'b0;
      wb_result       <= '0;
      wb_read_data    <= '0;
      wb_dest_reg_sel <= '0;
      wb_alu_to_reg   <= 1'b0;
      wb_mem_to_reg   <= 1'b0;
      wb_stall        <= 1'b0;
      exception       <= 1'b0;
    end else begin
      if ((r_state == ST_RUN) && ex_valid)
        r_squash <= r_squash ? 1'b0 : w_redirect;

      if (w_mem_misal || w_tgt_misal || w_timeout)
        exception <= 1'b1;

      case (r_state)
        ST_RUN: begin
          if (w_mem_go && !dmem_ready) begin
            r_state <= ST_WAIT;
            r_cnt   <= '0;
            r_addr  <= w_mem_addr;
            r_wdata <= w_st_wdata;
            r_be    <= w_st_be;
            r_we    <= ex_mem_write;
            r_load  <= ex_mem_to_reg;
            r_func3 <= ex_func3;
            r_rd    <= ex_rd;
            r_res   <= w_result;
          end
        end
        ST_WAIT: begin
          if (dmem_ready || w_timeout) r_state <= ST_RUN;
          else                         r_cnt   <= r_cnt + 32'd1;
        end
        default: r_state <= ST_RUN;
      endcase

      if (w_retire) begin
        wb_result       <= w_sel_res;
        wb_dest_reg_sel <= w_sel_rd;
        wb_alu_to_reg   <= w_sel_we;
        wb_mem_to_reg   <= w_sel_load;
        wb_stall        <= 1'b0;
        if (w_sel_load)
          wb_read_data <= load_align(dmem_rdata, w_sel_addr[1:0], w_sel_f3);
      end else begin
        wb_alu_to_reg <= 1'b0;
        wb_mem_to_reg <= 1'b0;
        wb_stall      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed self-checking bench for ex_wb_stage: ALU, branches/squash, load/store lanes, timeout.
module tb_ex_wb_stage;

  logic        clk, reset;
  logic        ex_valid, ex_imm_sel, ex_alu, ex_lui, ex_jal, ex_jalr, ex_branch;
  logic        ex_mem_write, ex_mem_to_reg, ex_subtype;
  logic [31:0] ex_pc, ex_imm, ex_rs1, ex_rs2;
  logic [2:0]  ex_func3;
  logic [4:0]  ex_rd;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        redirect, stall, wb_alu_to_reg, wb_mem_to_reg, wb_stall, exception;
  logic [31:0] redirect_pc, wb_result, wb_read_data;
  logic [4:0]  wb_dest_reg_sel;

  int checks = 0;
  int errors = 0;
  int n;

  ex_wb_stage #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_imm_sel(ex_imm_sel), .ex_alu(ex_alu), .ex_lui(ex_lui), .ex_jal(ex_jal),
    .ex_jalr(ex_jalr), .ex_branch(ex_branch), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_func3(ex_func3), .ex_subtype(ex_subtype),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall(stall), .wb_result(wb_result),
    .wb_read_data(wb_read_data), .wb_dest_reg_sel(wb_dest_reg_sel),
    .wb_alu_to_reg(wb_alu_to_reg), .wb_mem_to_reg(wb_mem_to_reg), .wb_stall(wb_stall),
    .exception(exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; ex_imm_sel = 0; ex_alu = 0; ex_lui = 0; ex_jal = 0; ex_jalr = 0;
    ex_branch = 0; ex_mem_write = 0; ex_mem_to_reg = 0; ex_subtype = 0;
    ex_pc = '0; ex_imm = '0; ex_rs1 = '0; ex_rs2 = '0; ex_func3 = '0; ex_rd = '0;
    dmem_ready = 0; dmem_rdata = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    #3;
    reset = 1;
    tick();
  endtask

  initial begin
    // reset state, with a load presented to prove the request is held off
    reset = 0;
    idle();
    ex_valid = 1; ex_mem_to_reg = 1; ex_rs1 = 32'h1000;
    #2;
    chk("rst_wb_result", wb_result, 0);
    chk("rst_wb_alu", wb_alu_to_reg, 0);
    chk("rst_wb_stall", wb_stall, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_exc", exception, 0);
    idle();
    #10 reset = 1;
    tick();

    // ADD rs1=5 imm=-7
    ex_valid = 1; ex_alu = 1; ex_imm_sel = 1; ex_rs1 = 5; ex_imm = 32'hFFFF_FFF9; ex_rd = 3;
    #1;
    chk("add_redirect", redirect, 0);
    chk("add_stall", stall, 0);
    tick();
    chk("add_result", wb_result, 32'hFFFF_FFFE);
    chk("add_we", wb_alu_to_reg, 1);
    chk("add_rd", wb_dest_reg_sel, 3);
    chk("add_wbstall", wb_stall, 0);

    ex_func3 = 3'b101; ex_subtype = 1; ex_rs1 = 32'h8000_0000; ex_imm = 4; ex_rd = 4;
    tick();
    chk("sra", wb_result, 32'hF800_0000);
    ex_subtype = 0;
    tick();
    chk("srl", wb_result, 32'h0800_0000);

    ex_imm_sel = 0; ex_func3 = 3'b000; ex_subtype = 1; ex_rs1 = 3; ex_rs2 = 5;
    tick();
    chk("sub", wb_result, 32'hFFFF_FFFE);
    ex_subtype = 0; ex_func3 = 3'b011; ex_rs1 = 32'hFFFF_FFFF; ex_rs2 = 1;
    tick();
    chk("sltu", wb_result, 0);
    ex_func3 = 3'b010;
    tick();
    chk("slt", wb_result, 1);
    ex_func3 = 3'b000; ex_rd = 0;
    tick();
    chk("rd0_we", wb_alu_to_reg, 0);

    idle();
    tick();
    chk("bubble_stall", wb_stall, 1);
    chk("bubble_we", wb_alu_to_reg, 0);

    ex_valid = 1; ex_lui = 1; ex_imm = 32'h1234_5000; ex_rd = 9;
    tick();
    chk("lui", wb_result, 32'h1234_5000);

    // BNE taken, then the squashed instruction
    idle();
    ex_valid = 1; ex_branch = 1; ex_func3 = 3'b001; ex_pc = 32'h100; ex_imm = 32'h20;
    ex_rs1 = 1; ex_rs2 = 2;
    #1;
    chk("bne_redirect", redirect, 1);
    chk("bne_pc", redirect_pc, 32'h120);
    tick();
    chk("bne_we", wb_alu_to_reg, 0);
    chk("bne_wbstall", wb_stall, 0);

    idle();
    ex_valid = 1; ex_jal = 1; ex_pc = 32'h200; ex_imm = 8; ex_rd = 1;
    #1;
    chk("squash_redirect", redirect, 0);
    tick();
    chk("squash_wbstall", wb_stall, 1);
    chk("squash_we", wb_alu_to_reg, 0);
    #1;
    chk("jal_redirect", redirect, 1);
    chk("jal_pc", redirect_pc, 32'h208);
    tick();
    chk("jal_link", wb_result, 32'h204);
    chk("jal_we", wb_alu_to_reg, 1);

    // squash survives an invalid cycle and hits the next valid one
    idle();
    tick();
    ex_valid = 1; ex_alu = 1; ex_imm_sel = 1; ex_rs1 = 1; ex_imm = 1; ex_rd = 6;
    tick();
    chk("squash2_wbstall", wb_stall, 1);
    tick();
    chk("after_squash_res", wb_result, 2);
    chk("after_squash_wbstall", wb_stall, 0);

    idle();
    ex_valid = 1; ex_branch = 1; ex_func3 = 3'b000; ex_rs1 = 1; ex_rs2 = 2;
    #1;
    chk("beq_nt", redirect, 0);
    tick();

    idle();
    ex_valid = 1; ex_jalr = 1; ex_pc = 32'h40; ex_rs1 = 32'h301; ex_imm = 32'h10; ex_rd = 2;
    #1;
    chk("jalr_redirect", redirect, 1);
    chk("jalr_pc", redirect_pc, 32'h310);
    tick();
    chk("jalr_link", wb_result, 32'h44);
    idle();
    ex_valid = 1;
    tick();
    chk("no_exc_yet", exception, 0);

    idle();
    ex_valid = 1; ex_jal = 1; ex_pc = 32'h100; ex_imm = 2; ex_rd = 1;
    #1;
    chk("mis_tgt_redirect", redirect, 0);
    tick();
    chk("mis_tgt_exc", exception, 1);
    chk("mis_tgt_we", wb_alu_to_reg, 0);
    do_reset();
    chk("exc_cleared", exception, 0);

    // LH at 0x1002, ready after three stalled cycles
    ex_valid = 1; ex_mem_to_reg = 1; ex_imm_sel = 1; ex_func3 = 3'b001;
    ex_rs1 = 32'h1000; ex_imm = 2; ex_rd = 7;
    #1;
    chk("lh_req", dmem_req, 1);
    chk("lh_we", dmem_we, 0);
    chk("lh_addr", dmem_addr, 32'h1000);
    chk("lh_stall0", stall, 1);
    tick();
    chk("lh_wbstall", wb_stall, 1);
    for (int i = 0; i < 2; i++) begin
      chk("lh_wait_stall", stall, 1);
      chk("lh_wait_req", dmem_req, 1);
      chk("lh_wait_addr", dmem_addr, 32'h1000);
      tick();
    end
    dmem_ready = 1; dmem_rdata = 32'h8001_1234;
    #1;
    chk("lh_ready_stall", stall, 0);
    tick();
    idle();
    chk("lh_data", wb_read_data, 32'hFFFF_8001);
    chk("lh_m2r", wb_mem_to_reg, 1);
    chk("lh_we_wb", wb_alu_to_reg, 1);
    chk("lh_rd", wb_dest_reg_sel, 7);
    chk("lh_wbstall_done", wb_stall, 0);

    ex_valid = 1; ex_mem_to_reg = 1; ex_imm_sel = 1; ex_func3 = 3'b100;
    ex_rs1 = 32'h2000; ex_imm = 3; ex_rd = 8; dmem_ready = 1; dmem_rdata = 32'h9A00_0000;
    #1;
    chk("lbu_stall", stall, 0);
    tick();
    chk("lbu_data", wb_read_data, 32'h0000_009A);

    idle();
    ex_valid = 1; ex_mem_write = 1; ex_imm_sel = 1; ex_func3 = 3'b000;
    ex_rs1 = 32'h1000; ex_imm = 3; ex_rs2 = 32'h1234_56AB; dmem_ready = 1;
    #1;
    chk("sb_req", dmem_req, 1);
    chk("sb_we", dmem_we, 1);
    chk("sb_be", dmem_be, 4'b1000);
    chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    chk("sb_addr", dmem_addr, 32'h1000);
    tick();
    chk("sb_wb_we", wb_alu_to_reg, 0);
    chk("sb_exc", exception, 0);
    ex_func3 = 3'b001; ex_imm = 2; ex_rs2 = 32'h0000_BEEF;
    #1;
    chk("sh_be", dmem_be, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    tick();

    ex_func3 = 3'b010; ex_imm = 1; dmem_ready = 0;
    #1;
    chk("sw_mis_req", dmem_req, 0);
    chk("sw_mis_stall", stall, 0);
    tick();
    chk("sw_mis_exc", exception, 1);
    chk("sw_mis_we", wb_alu_to_reg, 0);
    idle();
    tick();
    chk("exc_sticky", exception, 1);

    // timeout on a load that never completes
    do_reset();
    ex_valid = 1; ex_mem_to_reg = 1; ex_imm_sel = 1; ex_func3 = 3'b010;
    ex_rs1 = 32'h3000; ex_rd = 10;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("to_stall_cycles", n, 16);
    chk("to_exc_before", exception, 0);
    idle();
    tick();
    chk("to_exc", exception, 1);
    chk("to_req", dmem_req, 0);
    chk("to_stall", stall, 0);
    chk("to_wbstall", wb_stall, 1);

    // reset while waiting
    do_reset();
    ex_valid = 1; ex_mem_to_reg = 1; ex_func3 = 3'b010; ex_rs1 = 32'h4000;
    tick();
    chk("rw_req", dmem_req, 1);
    reset = 0;
    #1;
    chk("rw_req_drop", dmem_req, 0);
    chk("rw_stall_drop", stall, 0);
    idle();
    #2 reset = 1;
    tick();
    chk("rw_req_after", dmem_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
